// File: rtl/rsa_req_arbiter.sv
// Round-robin arbiter sharing one RSA modexp engine between NREQ requesters, one job in flight.
// Accept->engine strobe 1 cycle, result->rsp_valid 1 cycle; a requester with an unconsumed result is not granted.
module rsa_req_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [32*NREQ-1:0]   rsp_data,
  output logic [NREQ-1:0]      rsp_err,
  input  logic [NREQ-1:0]      rsp_ready,
  input  logic                 core_ready,
  output logic                 core_in_vaild,
  output logic [31:0]          core_plaint,
  input  logic                 core_vaild,
  input  logic [31:0]          core_cipht,
  output logic                 busy,
  output logic [2:0]           owner
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]       state;
  logic [2:0]       rr_q;
  logic [2:0]       owner_q;
  logic [31:0]      job_q;
  logic [CNT_W-1:0] cnt_q;

  logic [NREQ-1:0]  eligible;
  logic [2:0]       pick;
  logic [31:0]      pick_data;
  logic             pick_vld;
  logic             grant;
  logic             timeout_hit;

  assign eligible = req_valid & ~rsp_valid;

  // Search starts one past the last grant and wraps, so each requester waits at most NREQ-1 jobs.
  always_comb begin
    pick      = '0;
    pick_vld  = 1'b0;
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!pick_vld && eligible[k] && (k == (int'(rr_q) + 1 + i) % NREQ)) begin
          pick_vld  = 1'b1;
          pick      = 3'(k);
          pick_data = req_data[32*k +: 32];
        end
      end
    end
  end

  assign grant = (state == IDLE) && core_ready && pick_vld;

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant && (pick == 3'(k))) req_ready[k] = 1'b1;
    end
  end

  assign core_in_vaild = (state == ISSUE);
  assign core_plaint   = (state == ISSUE) ? job_q : 32'h0;
  assign busy          = (state != IDLE);
  assign owner         = owner_q;
  assign timeout_hit   = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      rr_q      <= 3'(NREQ - 1);
      owner_q   <= '0;
      job_q     <= '0;
      cnt_q     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= '0;
    end else begin
      // Consumption first; a capture below targets the owner, whose slot is known to be empty.
      rsp_valid <= rsp_valid & ~rsp_ready;
      case (state)
        IDLE: begin
          if (grant) begin
            job_q   <= pick_data;
            owner_q <= pick;
            rr_q    <= pick;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (core_vaild) begin
            for (int k = 0; k < NREQ; k++) begin
              if (owner_q == 3'(k)) begin
                rsp_valid[k]          <= 1'b1;
                rsp_data[32*k +: 32]  <= core_cipht;
                rsp_err[k]            <= 1'b0;
              end
            end
            state <= IDLE;
          end else if (timeout_hit) begin
            for (int k = 0; k < NREQ; k++) begin
              if (owner_q == 3'(k)) begin
                rsp_valid[k]          <= 1'b1;
                rsp_data[32*k +: 32]  <= 32'h0;
                rsp_err[k]            <= 1'b1;
              end
            end
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // A stale engine result arriving here is dropped; leave once the engine is idle again.
          if (core_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_req_arbiter.sv
// Directed and randomized bench for rsa_req_arbiter with a cycle-arithmetic job model and a behavioural engine.
module tb_rsa_req_arbiter;
  localparam int N  = 2;
  localparam int TO = 48;
  localparam int CW = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_err, rsp_ready;
  logic [32*N-1:0]   req_data, rsp_data;
  logic              core_ready, core_in_vaild, core_vaild, busy;
  logic [31:0]       core_plaint, core_cipht;
  logic [2:0]        owner;

  rsa_req_arbiter #(.NREQ(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .core_ready(core_ready), .core_in_vaild(core_in_vaild), .core_plaint(core_plaint),
    .core_vaild(core_vaild), .core_cipht(core_cipht),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // model: job accepted at cycle m_acc, strobe at m_acc+1, wait cycle n at m_acc+1+n
  bit          m_on, m_drain;
  int          m_acc, m_owner, m_rr;
  logic [31:0] m_job;
  bit          m_pend [N];
  logic [31:0] m_pdat [N];
  bit          m_perr [N];
  int          grants [$];

  // engine: result L cycles after its strobe, then ready again
  bit          e_busy = 1'b0;
  int          e_left = 0;
  int          e_lat  = 3;
  bit          e_fix  = 1'b0;
  logic [31:0] e_res_next = 32'h0;
  logic [31:0] e_res = 32'h0;

  task automatic check32(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check1(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    int g;
    int c;
    bit iss;
    bit s_iss, s_vld, s_rdy;
    logic [31:0] s_plaint, s_cipht;
    core_ready = !e_busy;
    core_vaild = e_busy && (e_left == 0);
    core_cipht = core_vaild ? e_res : $urandom;
    #1;
    g = -1;
    if (!m_on && core_ready) begin
      for (int i = 1; i <= N; i++) begin
        c = (m_rr + i) % N;
        if (g < 0 && req_valid[c] && !m_pend[c]) g = c;
      end
    end
    iss = m_on && !m_drain && (cyc == m_acc + 1);
    if (chk_en) begin
      for (int k = 0; k < N; k++) check1("req_ready", req_ready[k], g == k);
      check1("core_in_vaild", core_in_vaild, iss);
      check32("core_plaint", core_plaint, iss ? m_job : 32'h0);
      check1("busy", busy, m_on);
      check32("owner", 32'(owner), m_owner);
      for (int k = 0; k < N; k++) begin
        check1("rsp_valid", rsp_valid[k], m_pend[k]);
        check1("rsp_err", rsp_err[k], m_perr[k]);
        check32("rsp_data", rsp_data[32*k +: 32], m_pdat[k]);
      end
    end
    s_iss = core_in_vaild; s_plaint = core_plaint;
    s_vld = core_vaild; s_rdy = core_ready; s_cipht = core_cipht;
    @(posedge clk);
    if (!reset) begin
      m_on = 0; m_drain = 0; m_acc = 0; m_owner = 0; m_rr = N - 1; m_job = 0;
      for (int k = 0; k < N; k++) begin m_pend[k] = 0; m_pdat[k] = 0; m_perr[k] = 0; end
      e_busy = 0; e_left = 0;
    end else begin
      for (int k = 0; k < N; k++) if (m_pend[k] && rsp_ready[k]) m_pend[k] = 0;
      if (g >= 0) begin
        m_on = 1; m_acc = cyc; m_owner = g; m_rr = g; m_job = req_data[32*g +: 32];
        grants.push_back(g);
      end else if (m_on && !m_drain && cyc >= m_acc + 2) begin
        if (s_vld) begin
          m_pend[m_owner] = 1; m_pdat[m_owner] = s_cipht; m_perr[m_owner] = 0; m_on = 0;
        end else if (cyc - m_acc - 1 == TO) begin
          m_pend[m_owner] = 1; m_pdat[m_owner] = 0; m_perr[m_owner] = 1; m_drain = 1;
        end
      end else if (m_drain && s_rdy) begin
        m_on = 0; m_drain = 0;
      end
      if (e_busy) begin
        if (e_left == 0) e_busy = 0; else e_left--;
      end else if (s_iss) begin
        e_busy = 1; e_left = e_lat - 1; e_res = e_fix ? e_res_next : ~s_plaint;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_data = '0; rsp_ready = '0;
    core_ready = 1'b0; core_vaild = 1'b0; core_cipht = '0;
    @(negedge clk);
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b1;

    // single job, engine answers 40 cycles after its strobe
    e_fix = 1; e_lat = 40; e_res_next = 32'h1234_5678;
    req_data[31:0] = 32'h0000_0041; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    run(45);
    check32("t1_grant", grants[0], 0);
    check1("t1_valid", rsp_valid[0], 1'b1);
    check32("t1_data", rsp_data[31:0], 32'h1234_5678);
    rsp_ready = 2'b01; step(); rsp_ready = 2'b00;

    // contention after reset: grants alternate starting at 0
    reset = 1'b0; step(); reset = 1'b1;
    grants.delete();
    e_fix = 0; e_lat = 3;
    req_data = {32'h0000_00B1, 32'h0000_00A0};
    req_valid = 2'b11; rsp_ready = 2'b11;
    run(22);
    req_valid = 2'b00;
    run(8);
    check32("t2_count", grants.size() >= 4, 1);
    if (grants.size() >= 4) begin
      check32("t2_g0", grants[0], 0);
      check32("t2_g1", grants[1], 1);
      check32("t2_g2", grants[2], 0);
      check32("t2_g3", grants[3], 1);
    end
    check32("t2_data0", rsp_data[31:0], 32'hFFFF_FF5F);
    check32("t2_data1", rsp_data[63:32], 32'hFFFF_FF4E);
    rsp_ready = 2'b00;

    // backpressure: pending result blocks requester 0 only
    grants.delete();
    req_data = {32'h0000_0022, 32'h0000_0011};
    req_valid = 2'b01;
    run(8);
    check32("t3_n1", grants.size(), 1);
    req_valid = 2'b11;
    run(8);
    check32("t3_n2", grants.size(), 2);
    check32("t3_g1", grants[grants.size()-1], 1);
    rsp_ready = 2'b01; step(); rsp_ready = 2'b00;
    run(3);
    check32("t3_n3", grants.size(), 3);
    check32("t3_g2", grants[grants.size()-1], 0);
    req_valid = 2'b00; rsp_ready = 2'b11;
    run(10);
    rsp_ready = 2'b00;

    // watchdog: engine answers late, result discarded in drain
    e_fix = 1; e_lat = TO + 10; e_res_next = 32'hDEAD_BEEF;
    grants.delete();
    req_data[31:0] = 32'h0000_0099; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    run(TO + 15);
    check32("t4_grant", grants[0], 0);
    check1("t4_valid", rsp_valid[0], 1'b1);
    check1("t4_err", rsp_err[0], 1'b1);
    check32("t4_data", rsp_data[31:0], 32'h0);
    check1("t4_busy", busy, 1'b0);
    rsp_ready = 2'b01; step(); rsp_ready = 2'b00;

    // race: result on the final watchdog cycle is kept
    e_lat = TO; e_res_next = 32'hCAFE_0005;
    grants.delete();
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    run(TO + 5);
    check1("t5_valid", rsp_valid[0], 1'b1);
    check1("t5_err", rsp_err[0], 1'b0);
    check32("t5_data", rsp_data[31:0], 32'hCAFE_0005);
    rsp_ready = 2'b01; step(); rsp_ready = 2'b00;

    // reset while waiting on the engine
    e_lat = 30;
    grants.delete();
    req_data[63:32] = 32'h0000_0077; req_valid = 2'b10;
    step();
    run(10);
    check1("t6_busy_before", busy, 1'b1);
    reset = 1'b0; step(); reset = 1'b1;
    check1("t6_busy", busy, 1'b0);
    check32("t6_owner", 32'(owner), 0);
    check32("t6_rspv", 32'(rsp_valid), 0);
    req_valid = 2'b11;
    step();
    req_valid = 2'b00;
    check32("t6_grant", grants[grants.size()-1], 0);
    run(40);
    rsp_ready = 2'b11; run(2); rsp_ready = 2'b00;

    // randomized traffic, including engine latencies past the watchdog
    e_fix = 0;
    for (int c = 0; c < 3000; c++) begin
      req_valid = N'($urandom);
      rsp_ready = N'($urandom);
      req_data  = {$urandom, $urandom};
      if (!e_busy) e_lat = $urandom_range(TO + 8, 1);
      step();
    end
    req_valid = '0; rsp_ready = '1;
    run(TO + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
